// File: rtl/mem_request_arbiter_pkg.sv
// mem_request_arbiter_pkg
//   Shared definitions for the memory request arbiter:
//   - arb_state_e : arbiter FSM encodings
//   - op field    : bit 2 = store, bits 1:0 = access size
//   - grant_t     : one-hot grant vector from the priority picker
//   - STARVE_W    : width of the fetch starvation counter
package mem_request_arbiter_pkg;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY_FETCH = 2'd1,
    ST_BUSY_LOAD  = 2'd2,
    ST_BUSY_STORE = 2'd3
  } arb_state_e;

  // Op field layout shared by loads and stores.
  localparam int OP_STORE_BIT = 2;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b11
  } op_size_e;

  typedef struct packed {
    logic store;
    logic load;
    logic fetch;
  } grant_t;

  function automatic logic is_data_grant(grant_t g);
    return g.store | g.load;
  endfunction

endpackage

// File: rtl/mem_request_arbiter_if.sv
// mem_request_arbiter_if
//   Bundles the requester-side handshakes (fetch, load, store, read data)
//   and the memory-controller side (icache and lsb request ports).
//   Modports:
//     slave  : the arbiter's view (takes requests, drives the controller)
//     master : the environment's view (requesters plus controller)
interface mem_request_arbiter_if;

  // Requester side
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchDone;
  logic        loadReq;
  logic [2:0]  loadOp;
  logic [31:0] loadAddr;
  logic        loadDone;
  logic        storeReq;
  logic [2:0]  storeOp;
  logic [31:0] storeAddr;
  logic [31:0] storeData;
  logic        storeDone;
  logic [31:0] rdData;

  // Memory controller side
  logic        mcIcacheFlag;
  logic [31:0] mcIcacheAddr;
  logic        mcIcacheOk;
  logic        mcLsbFlag;
  logic [2:0]  mcLsbOp;
  logic [31:0] mcLsbAddr;
  logic [31:0] mcLsbData;
  logic        mcLsbOk;
  logic [31:0] mcData;

  modport slave (
    input  fetchReq, fetchAddr, loadReq, loadOp, loadAddr,
           storeReq, storeOp, storeAddr, storeData,
           mcIcacheOk, mcLsbOk, mcData,
    output fetchDone, loadDone, storeDone, rdData,
           mcIcacheFlag, mcIcacheAddr, mcLsbFlag, mcLsbOp, mcLsbAddr, mcLsbData
  );

  modport master (
    output fetchReq, fetchAddr, loadReq, loadOp, loadAddr,
           storeReq, storeOp, storeAddr, storeData,
           mcIcacheOk, mcLsbOk, mcData,
    input  fetchDone, loadDone, storeDone, rdData,
           mcIcacheFlag, mcIcacheAddr, mcLsbFlag, mcLsbOp, mcLsbAddr, mcLsbData
  );

endinterface

// File: rtl/mem_request_arbiter_pick.sv
// mem_arb_pick
//   Priority select between fetch, store and load plus the fetch
//   starvation counter.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     ready        : global ready; counter only moves when high
//     enable       : arbiter is idle and may grant this cycle
//     clear        : mispredict flush (blocks speculative grants)
//     fetch_req, load_req, store_req : request levels
//     grant        : one-hot grant, valid only while enable is high
//     starve_force : (ARB_PERF_CNT_EN only) fetch grant won by starvation
//   Optional feature macro: ARB_PERF_CNT_EN adds the starve_force output.
module mem_arb_pick
  import mem_request_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ready,
  input  logic   enable,
  input  logic   clear,
  input  logic   fetch_req,
  input  logic   load_req,
  input  logic   store_req,
`ifdef ARB_PERF_CNT_EN
  output logic   starve_force,
`endif
  output grant_t grant
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_hit;

  // Starvation overrides everything, including the mispredict flush:
  // a forced fetch is the oldest outstanding work in the machine.
  assign starve_hit = fetch_req && (starve_cnt == LIMIT);

  always_comb begin
    // NOTE: grant is defaulted before the priority chain so no path through
    // this block leaves it unassigned, which would otherwise infer a latch.
    grant = '0;
    if (enable) begin
      if (starve_hit)                grant.fetch = 1'b1;
      else if (store_req)            grant.store = 1'b1;
      else if (load_req && !clear)   grant.load  = 1'b1;
      else if (fetch_req && !clear)  grant.fetch = 1'b1;
    end
  end

`ifdef ARB_PERF_CNT_EN
  assign starve_force = enable && starve_hit;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (ready) begin
      if (grant.fetch) begin
        starve_cnt <= '0;
      end else if (is_data_grant(grant) && fetch_req) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + STARVE_W'(1);
      end else if (!fetch_req) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
//   Shares the single memory controller between instruction fetch,
//   speculative loads and committed stores. One request is outstanding at a
//   time and its address/op/data stay latched until completion. A mispredict
//   clear drops an in-flight fetch or load; stores always complete.
//   Ports:
//     clockIn  : system clock
//     resetIn  : synchronous active-low reset
//     readyIn  : global ready; state and completions advance only when high
//     clearIn  : mispredict flush
//     bus      : requester and controller handshakes (slave modport)
//     perf*    : (ARB_PERF_CNT_EN only) 32-bit wrapping grant counters
//   Optional feature macro: ARB_PERF_CNT_EN.
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clockIn,
  input  logic resetIn,
  input  logic readyIn,
  input  logic clearIn,
  mem_request_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perfFetchGnt,
  output logic [31:0] perfLoadGnt,
  output logic [31:0] perfStoreGnt,
  output logic [31:0] perfStarveForce
`endif
);

  arb_state_e  state_q, state_d;
  grant_t      grant;
  logic        grant_en;
  logic        any_done;

  logic        fetch_done_d, load_done_d, store_done_d;
  logic        fetch_done_q, load_done_q, store_done_q;
  logic [31:0] rd_data_q;
  logic [31:0] fetch_addr_q;
  logic [2:0]  lsb_op_q;
  logic [31:0] lsb_addr_q;
  logic [31:0] lsb_data_q;

`ifdef ARB_PERF_CNT_EN
  logic starve_force;
`endif

  // No re-grant in the Done cycle: the requester still shows its old
  // request level there, so this guarantees one idle cycle between jobs.
  assign any_done = fetch_done_q | load_done_q | store_done_q;
  assign grant_en = readyIn && (state_q == ST_IDLE) && !any_done;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk          (clockIn),
    .rst_n        (resetIn),
    .ready        (readyIn),
    .enable       (grant_en),
    .clear        (clearIn),
    .fetch_req    (bus.fetchReq),
    .load_req     (bus.loadReq),
    .store_req    (bus.storeReq),
`ifdef ARB_PERF_CNT_EN
    .starve_force (starve_force),
`endif
    .grant        (grant)
  );

  // Next state and completion pulses. Clear beats ok for fetch/load so a
  // squashed speculative access never reports completion.
  always_comb begin
    state_d      = state_q;
    fetch_done_d = 1'b0;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    if (readyIn) begin
      case (state_q)
        ST_IDLE: begin
          if (grant.fetch)      state_d = ST_BUSY_FETCH;
          else if (grant.store) state_d = ST_BUSY_STORE;
          else if (grant.load)  state_d = ST_BUSY_LOAD;
        end
        ST_BUSY_FETCH: begin
          if (clearIn) begin
            state_d = ST_IDLE;
          end else if (bus.mcIcacheOk) begin
            state_d      = ST_IDLE;
            fetch_done_d = 1'b1;
          end
        end
        ST_BUSY_LOAD: begin
          if (clearIn) begin
            state_d = ST_IDLE;
          end else if (bus.mcLsbOk) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
        ST_BUSY_STORE: begin
          if (bus.mcLsbOk) begin
            state_d      = ST_IDLE;
            store_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clockIn) begin
    if (!resetIn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      // NOTE: the latched request fields are reset as well, so the controller
      // ports read zero rather than stale or unknown values after reset.
      fetch_done_q <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      rd_data_q    <= '0;
      fetch_addr_q <= '0;
      lsb_op_q     <= '0;
      lsb_addr_q   <= '0;
      lsb_data_q   <= '0;
    end else begin
      fetch_done_q <= fetch_done_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      if (fetch_done_d || load_done_d) rd_data_q <= bus.mcData;
      if (grant.fetch) fetch_addr_q <= bus.fetchAddr;
      if (grant.store) begin
        lsb_op_q   <= bus.storeOp;
        lsb_addr_q <= bus.storeAddr;
        lsb_data_q <= bus.storeData;
      end else if (grant.load) begin
        lsb_op_q   <= bus.loadOp;
        lsb_addr_q <= bus.loadAddr;
        lsb_data_q <= '0;
      end
    end
  end

  assign bus.fetchDone = fetch_done_q;
  assign bus.loadDone  = load_done_q;
  assign bus.storeDone = store_done_q;
  assign bus.rdData    = rd_data_q;

  // Flags drop on the ok cycle so the controller never sees a second launch
  // while it is finishing; a flush kills fetch/load flags combinationally.
  assign bus.mcIcacheFlag = (state_q == ST_BUSY_FETCH) && !bus.mcIcacheOk && !clearIn;
  assign bus.mcLsbFlag    = ((state_q == ST_BUSY_LOAD) && !bus.mcLsbOk && !clearIn)
                         || ((state_q == ST_BUSY_STORE) && !bus.mcLsbOk);
  assign bus.mcIcacheAddr = fetch_addr_q;
  assign bus.mcLsbOp      = lsb_op_q;
  assign bus.mcLsbAddr    = lsb_addr_q;
  assign bus.mcLsbData    = lsb_data_q;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      perfFetchGnt    <= '0;
      perfLoadGnt     <= '0;
      perfStoreGnt    <= '0;
      perfStarveForce <= '0;
    end else begin
      if (grant.fetch)  perfFetchGnt    <= perfFetchGnt + 32'd1;
      if (grant.load)   perfLoadGnt     <= perfLoadGnt + 32'd1;
      if (grant.store)  perfStoreGnt    <= perfStoreGnt + 32'd1;
      if (starve_force) perfStarveForce <= perfStarveForce + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter
//   Directed bench for mem_request_arbiter with STARVE_LIMIT = 4. Each task
//   drives one scenario and compares outputs against hand-computed values.
module tb_mem_request_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic ready;
  logic clear;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [31:0] last_rd;

  mem_request_arbiter_if bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_load, perf_store, perf_starve;
`endif

  mem_request_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clockIn (clk),
    .resetIn (rst_n),
    .readyIn (ready),
    .clearIn (clear),
`ifdef ARB_PERF_CNT_EN
    .perfFetchGnt    (perf_fetch),
    .perfLoadGnt     (perf_load),
    .perfStoreGnt    (perf_store),
    .perfStarveForce (perf_starve),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; registered outputs are settled here.
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc();
    cyc();
    chk_cnt++;
    if ({bus.fetchDone, bus.loadDone, bus.storeDone, bus.mcIcacheFlag, bus.mcLsbFlag} !== 5'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.fetchDone, bus.loadDone, bus.storeDone, bus.mcIcacheFlag, bus.mcLsbFlag});
    end
    chk_cnt++;
    if (bus.rdData !== 32'h0) begin
      err_cnt++; $display("FAIL reset_rddata: got %h want 0", bus.rdData);
    end
    chk_cnt++;
    if ({bus.mcIcacheAddr, bus.mcLsbAddr, bus.mcLsbData, bus.mcLsbOp} !== 99'h0) begin
      err_cnt++; $display("FAIL reset_latched: got %h %h %h %h want 0", bus.mcIcacheAddr,
                          bus.mcLsbAddr, bus.mcLsbData, bus.mcLsbOp);
    end
    rst_n = 1'b1;
    cyc();
    last_rd = 32'h0;
  endtask

  task automatic test_fetch;
    bus.fetchReq  = 1'b1;
    bus.fetchAddr = 32'h0000_0100;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (bus.mcIcacheFlag !== 1'b1) begin
        err_cnt++; $display("FAIL fetch_flag[%0d]: got %b want 1", i, bus.mcIcacheFlag);
      end
      if (i < 3) cyc();
    end
    chk_cnt++;
    if (bus.mcIcacheAddr !== 32'h100) begin
      err_cnt++; $display("FAIL fetch_addr: got %h want 00000100", bus.mcIcacheAddr);
    end
    cyc();
    bus.mcIcacheOk = 1'b1;
    bus.mcData     = 32'hDEAD_BEEF;
    #1;
    chk_cnt++;
    if ({bus.mcIcacheFlag, bus.fetchDone} !== 2'b00) begin
      err_cnt++; $display("FAIL fetch_ok_cycle: got %b want 00", {bus.mcIcacheFlag, bus.fetchDone});
    end
    cyc();
    bus.mcIcacheOk = 1'b0;
    bus.fetchReq   = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.fetchDone, bus.mcIcacheFlag} !== 2'b10) begin
      err_cnt++; $display("FAIL fetch_done: got %b want 10", {bus.fetchDone, bus.mcIcacheFlag});
    end
    chk_cnt++;
    if (bus.rdData !== 32'hDEAD_BEEF) begin
      err_cnt++; $display("FAIL fetch_rddata: got %h want deadbeef", bus.rdData);
    end
    last_rd = 32'hDEAD_BEEF;
    cyc();
    chk_cnt++;
    if (bus.fetchDone !== 1'b0) begin
      err_cnt++; $display("FAIL fetch_done_pulse: got %b want 0", bus.fetchDone);
    end
  endtask

  task automatic test_priority;
    bus.fetchReq  = 1'b1; bus.fetchAddr = 32'h200;
    bus.loadReq   = 1'b1; bus.loadAddr  = 32'h300; bus.loadOp = 3'b011;
    bus.storeReq  = 1'b1; bus.storeAddr = 32'h400; bus.storeOp = 3'b111;
    bus.storeData = 32'hCAFE_F00D;
    cyc();
    chk_cnt++;
    if ({bus.mcIcacheFlag, bus.mcLsbFlag, bus.mcLsbOp} !== 5'b01_111) begin
      err_cnt++; $display("FAIL prio_store_first: got %b want 01111",
                          {bus.mcIcacheFlag, bus.mcLsbFlag, bus.mcLsbOp});
    end
    chk_cnt++;
    if ({bus.mcLsbAddr, bus.mcLsbData} !== {32'h400, 32'hCAFE_F00D}) begin
      err_cnt++; $display("FAIL prio_store_payload: got %h %h want 00000400 cafef00d",
                          bus.mcLsbAddr, bus.mcLsbData);
    end
    bus.mcLsbOk = 1'b1;
    #1;
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b0) begin
      err_cnt++; $display("FAIL prio_lsb_ok_gate: got %b want 0", bus.mcLsbFlag);
    end
    cyc();
    bus.mcLsbOk  = 1'b0;
    bus.storeReq = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.storeDone, bus.loadDone, bus.fetchDone} !== 3'b100) begin
      err_cnt++; $display("FAIL prio_store_done: got %b want 100",
                          {bus.storeDone, bus.loadDone, bus.fetchDone});
    end
    chk_cnt++;
    if (bus.rdData !== last_rd) begin
      err_cnt++; $display("FAIL prio_store_rddata: got %h want %h", bus.rdData, last_rd);
    end
    cyc();
    chk_cnt++;
    if ({bus.mcIcacheFlag, bus.mcLsbFlag, bus.storeDone} !== 3'b000) begin
      err_cnt++; $display("FAIL prio_no_regrant_in_done: got %b want 000",
                          {bus.mcIcacheFlag, bus.mcLsbFlag, bus.storeDone});
    end
    cyc();
    chk_cnt++;
    if ({bus.mcIcacheFlag, bus.mcLsbFlag, bus.mcLsbOp} !== 5'b01_011) begin
      err_cnt++; $display("FAIL prio_load_second: got %b want 01011",
                          {bus.mcIcacheFlag, bus.mcLsbFlag, bus.mcLsbOp});
    end
    chk_cnt++;
    if (bus.mcLsbAddr !== 32'h300) begin
      err_cnt++; $display("FAIL prio_load_addr: got %h want 00000300", bus.mcLsbAddr);
    end
    bus.mcLsbOk = 1'b1;
    bus.mcData  = 32'h1122_3344;
    cyc();
    bus.mcLsbOk = 1'b0;
    bus.loadReq = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.loadDone, bus.rdData} !== {1'b1, 32'h1122_3344}) begin
      err_cnt++; $display("FAIL prio_load_done: got %b %h want 1 11223344", bus.loadDone, bus.rdData);
    end
    last_rd = 32'h1122_3344;
    cyc();
    cyc();
    chk_cnt++;
    if ({bus.mcIcacheFlag, bus.mcLsbFlag, bus.mcIcacheAddr} !== {2'b10, 32'h200}) begin
      err_cnt++; $display("FAIL prio_fetch_third: got %b %h want 10 00000200",
                          {bus.mcIcacheFlag, bus.mcLsbFlag}, bus.mcIcacheAddr);
    end
    bus.mcIcacheOk = 1'b1;
    bus.mcData     = 32'h55AA_55AA;
    cyc();
    bus.mcIcacheOk = 1'b0;
    bus.fetchReq   = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.fetchDone, bus.rdData} !== {1'b1, 32'h55AA_55AA}) begin
      err_cnt++; $display("FAIL prio_fetch_done: got %b %h want 1 55aa55aa", bus.fetchDone, bus.rdData);
    end
    last_rd = 32'h55AA_55AA;
    cyc();
  endtask

  // Fetch held while four data grants alternate store/load; the fifth
  // idle pick must go to fetch even though store and load are both pending.
  task automatic test_back_to_back;
    logic is_st;
    bus.fetchReq  = 1'b1;
    bus.fetchAddr = 32'h500;
    bus.storeOp   = 3'b101;
    bus.loadOp    = 3'b011;
    for (int i = 0; i < 4; i++) begin
      is_st        = (i % 2 == 0);
      bus.storeReq = is_st;
      bus.loadReq  = !is_st;
      bus.storeAddr = 32'h1000 + 32'(i);
      bus.loadAddr  = 32'h2000 + 32'(i);
      cyc();
      chk_cnt++;
      if ({bus.mcIcacheFlag, bus.mcLsbFlag} !== 2'b01) begin
        err_cnt++; $display("FAIL b2b_data_grant[%0d]: got %b want 01", i,
                            {bus.mcIcacheFlag, bus.mcLsbFlag});
      end
      chk_cnt++;
      if (bus.mcLsbOp !== (is_st ? 3'b101 : 3'b011)) begin
        err_cnt++; $display("FAIL b2b_op[%0d]: got %b want %b", i, bus.mcLsbOp,
                            (is_st ? 3'b101 : 3'b011));
      end
      bus.storeReq = 1'b0;
      bus.loadReq  = 1'b0;
      bus.mcLsbOk  = 1'b1;
      bus.mcData   = 32'(i);
      cyc();
      bus.mcLsbOk = 1'b0;
      #1;
      chk_cnt++;
      if ({bus.storeDone, bus.loadDone} !== {is_st, !is_st}) begin
        err_cnt++; $display("FAIL b2b_done[%0d]: got %b want %b", i,
                            {bus.storeDone, bus.loadDone}, {is_st, !is_st});
      end
      cyc();
    end
    last_rd       = 32'd3;
    bus.storeReq  = 1'b1;
    bus.loadReq   = 1'b1;
    bus.storeAddr = 32'h3000;
    cyc();
    chk_cnt++;
    if ({bus.mcIcacheFlag, bus.mcLsbFlag, bus.mcIcacheAddr} !== {2'b10, 32'h500}) begin
      err_cnt++; $display("FAIL b2b_starve_force: got %b %h want 10 00000500",
                          {bus.mcIcacheFlag, bus.mcLsbFlag}, bus.mcIcacheAddr);
    end
    bus.mcIcacheOk = 1'b1;
    bus.mcData     = 32'hF00D_F00D;
    cyc();
    bus.mcIcacheOk = 1'b0;
    bus.fetchReq   = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.fetchDone, bus.rdData} !== {1'b1, 32'hF00D_F00D}) begin
      err_cnt++; $display("FAIL b2b_fetch_done: got %b %h want 1 f00df00d", bus.fetchDone, bus.rdData);
    end
    last_rd = 32'hF00D_F00D;
    cyc();
    cyc();
    chk_cnt++;
    if ({bus.mcIcacheFlag, bus.mcLsbFlag, bus.mcLsbOp, bus.mcLsbAddr} !== {5'b01_101, 32'h3000}) begin
      err_cnt++; $display("FAIL b2b_store_after_force: got %b %b %h want 01 101 00003000",
                          {bus.mcIcacheFlag, bus.mcLsbFlag}, bus.mcLsbOp, bus.mcLsbAddr);
    end
    bus.mcLsbOk  = 1'b1;
    bus.storeReq = 1'b0;
    bus.loadReq  = 1'b0;
    cyc();
    bus.mcLsbOk = 1'b0;
    #1;
    chk_cnt++;
    if (bus.storeDone !== 1'b1) begin
      err_cnt++; $display("FAIL b2b_store_done: got %b want 1", bus.storeDone);
    end
    cyc();
  endtask

  task automatic test_clear;
    // Clear while a load waits on the controller.
    bus.loadReq = 1'b1; bus.loadOp = 3'b001; bus.loadAddr = 32'h600;
    cyc();
    bus.loadReq = 1'b0;
    cyc();
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b1) begin
      err_cnt++; $display("FAIL clr_load_busy: got %b want 1", bus.mcLsbFlag);
    end
    clear = 1'b1;
    #1;
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b0) begin
      err_cnt++; $display("FAIL clr_load_flag_drop: got %b want 0", bus.mcLsbFlag);
    end
    cyc();
    clear = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.loadDone, bus.mcLsbFlag, bus.rdData} !== {2'b00, last_rd}) begin
      err_cnt++; $display("FAIL clr_load_idle: got %b %h want 00 %h",
                          {bus.loadDone, bus.mcLsbFlag}, bus.rdData, last_rd);
    end
    cyc();
    chk_cnt++;
    if (bus.loadDone !== 1'b0) begin
      err_cnt++; $display("FAIL clr_load_no_done: got %b want 0", bus.loadDone);
    end

    // Clear and ok in the same cycle: clear wins.
    bus.loadReq = 1'b1;
    cyc();
    bus.loadReq = 1'b0;
    clear       = 1'b1;
    bus.mcLsbOk = 1'b1;
    bus.mcData  = 32'h9999_9999;
    cyc();
    clear       = 1'b0;
    bus.mcLsbOk = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.loadDone, bus.mcLsbFlag, bus.rdData} !== {2'b00, last_rd}) begin
      err_cnt++; $display("FAIL clr_ok_race: got %b %h want 00 %h",
                          {bus.loadDone, bus.mcLsbFlag}, bus.rdData, last_rd);
    end
    cyc();

    // Clear during a fetch.
    bus.fetchReq = 1'b1; bus.fetchAddr = 32'h700;
    cyc();
    bus.fetchReq = 1'b0;
    clear        = 1'b1;
    #1;
    chk_cnt++;
    if (bus.mcIcacheFlag !== 1'b0) begin
      err_cnt++; $display("FAIL clr_fetch_flag_drop: got %b want 0", bus.mcIcacheFlag);
    end
    cyc();
    clear = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.fetchDone, bus.mcIcacheFlag} !== 2'b00) begin
      err_cnt++; $display("FAIL clr_fetch_idle: got %b want 00", {bus.fetchDone, bus.mcIcacheFlag});
    end
    cyc();

    // A store ignores clear and still completes.
    bus.storeReq = 1'b1; bus.storeAddr = 32'h800; bus.storeData = 32'h0BAD_F00D; bus.storeOp = 3'b111;
    cyc();
    bus.storeReq = 1'b0;
    clear        = 1'b1;
    #1;
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b1) begin
      err_cnt++; $display("FAIL clr_store_flag_kept: got %b want 1", bus.mcLsbFlag);
    end
    cyc();
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b1) begin
      err_cnt++; $display("FAIL clr_store_still_busy: got %b want 1", bus.mcLsbFlag);
    end
    bus.mcLsbOk = 1'b1;
    cyc();
    chk_cnt++;
    if (bus.storeDone !== 1'b1) begin
      err_cnt++; $display("FAIL clr_store_done: got %b want 1", bus.storeDone);
    end
    bus.mcLsbOk = 1'b0;
    clear       = 1'b0;
    cyc();
    chk_cnt++;
    if (bus.storeDone !== 1'b0) begin
      err_cnt++; $display("FAIL clr_store_done_pulse: got %b want 0", bus.storeDone);
    end
  endtask

  task automatic test_ready_stall;
    bus.loadReq = 1'b1; bus.loadOp = 3'b000; bus.loadAddr = 32'h900;
    cyc();
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b1) begin
      err_cnt++; $display("FAIL stall_load_busy: got %b want 1", bus.mcLsbFlag);
    end
    bus.loadReq = 1'b0;
    ready       = 1'b0;
    bus.mcLsbOk = 1'b1;
    bus.mcData  = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_cnt++;
      if ({bus.loadDone, bus.rdData} !== {1'b0, last_rd}) begin
        err_cnt++; $display("FAIL stall_hold[%0d]: got %b %h want 0 %h", i, bus.loadDone,
                            bus.rdData, last_rd);
      end
    end
    bus.mcLsbOk = 1'b0;
    #1;
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b1) begin
      err_cnt++; $display("FAIL stall_still_busy: got %b want 1", bus.mcLsbFlag);
    end
    bus.mcLsbOk = 1'b1;
    ready       = 1'b1;
    cyc();
    bus.mcLsbOk = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.loadDone, bus.rdData} !== {1'b1, 32'h1234_5678}) begin
      err_cnt++; $display("FAIL stall_complete: got %b %h want 1 12345678", bus.loadDone, bus.rdData);
    end
    last_rd = 32'h1234_5678;
    cyc();
  endtask

  task automatic test_reset_mid_store;
    bus.storeReq = 1'b1; bus.storeAddr = 32'hA00; bus.storeData = 32'h0000_BEEF; bus.storeOp = 3'b111;
    cyc();
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b1) begin
      err_cnt++; $display("FAIL rst_store_busy: got %b want 1", bus.mcLsbFlag);
    end
    rst_n = 1'b0;
    cyc();
    chk_cnt++;
    if ({bus.fetchDone, bus.loadDone, bus.storeDone, bus.mcIcacheFlag, bus.mcLsbFlag} !== 5'b0) begin
      err_cnt++; $display("FAIL rst_mid_ctrl: got %b want 00000",
                          {bus.fetchDone, bus.loadDone, bus.storeDone, bus.mcIcacheFlag, bus.mcLsbFlag});
    end
    chk_cnt++;
    if ({bus.rdData, bus.mcLsbAddr, bus.mcLsbData} !== 96'h0) begin
      err_cnt++; $display("FAIL rst_mid_data: got %h %h %h want 0", bus.rdData, bus.mcLsbAddr,
                          bus.mcLsbData);
    end
    bus.storeReq = 1'b0;
    rst_n        = 1'b1;
    cyc();
    chk_cnt++;
    if (bus.mcLsbFlag !== 1'b0) begin
      err_cnt++; $display("FAIL rst_mid_idle: got %b want 0", bus.mcLsbFlag);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    ready          = 1'b1;
    clear          = 1'b0;
    last_rd        = 32'h0;
    bus.fetchReq   = 1'b0; bus.fetchAddr = '0;
    bus.loadReq    = 1'b0; bus.loadOp    = '0; bus.loadAddr = '0;
    bus.storeReq   = 1'b0; bus.storeOp   = '0; bus.storeAddr = '0; bus.storeData = '0;
    bus.mcIcacheOk = 1'b0; bus.mcLsbOk   = 1'b0; bus.mcData = '0;

    test_reset();
    test_fetch();
    test_priority();
    test_back_to_back();
    test_clear();
    test_ready_stall();
    test_reset_mid_store();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
Shares the single memory controller between three requesters: instruction fetch (icache miss), speculative load (LSB) and committed store (store commit path). Keeps at most one outstanding request to the controller and holds it stable until completion. Drops fetch/load on branch-mispredict clear; stores always complete. Sits between icache/LSB and the memory controller's icache/lsb ports.

Parameters:
STARVE_LIMIT, 4, consecutive data (load/store) grants allowed while fetch waits before fetch is forced next (1..15)

Ports:
clockIn  in  1  system clock
resetIn  in  1  synchronous, active-low reset
readyIn  in  1  global ready; state advances only when 1
clearIn  in  1  mispredict flush
fetchReq  in  1  fetch request (level, held until fetchDone)
fetchAddr  in  32  fetch word address
fetchDone  out  1  one-cycle completion pulse
loadReq  in  1  load request (level)
loadOp  in  3  {0,size}; size 00 byte, 01 half, 11 word
loadAddr  in  32  load address
loadDone  out  1  one-cycle completion pulse
storeReq  in  1  store request (level)
storeOp  in  3  {1,size}
storeAddr  in  32  store address
storeData  in  32  store data
storeDone  out  1  one-cycle completion pulse
rdData  out  32  registered read data, valid with fetchDone/loadDone
mcIcacheFlag  out  1  to controller icache request
mcIcacheAddr  out  32  to controller
mcIcacheOk  in  1  controller fetch done
mcLsbFlag  out  1  to controller lsb request
mcLsbOp  out  3  to controller
mcLsbAddr  out  32  to controller
mcLsbData  out  32  to controller store data
mcLsbOk  in  1  controller load/store done
mcData  in  32  controller read data

Behaviour:
- Reset (resetIn=0 at clock edge): state IDLE, starveCnt=0, all Done=0, rdData=0, latched addr/op/data=0; mc flags 0.
- States: IDLE, BUSY_FETCH, BUSY_LOAD, BUSY_STORE. No transitions when readyIn=0; mcOk inputs are ignored when readyIn=0.
- IDLE pick (readyIn=1), in priority order:
  - fetchReq and starveCnt==STARVE_LIMIT -> fetch.
  - else storeReq -> store.
  - else loadReq and !clearIn -> load.
  - else fetchReq and !clearIn -> fetch.
  - On grant: latch addr/op/data, enter BUSY_x.
  - starveCnt: data grant while fetchReq=1 -> +1, saturating at STARVE_LIMIT; fetch grant or fetchReq=0 -> 0.
- Downstream flags are combinational off the state, gated so the controller never re-launches on its ok cycle:
  - mcIcacheFlag = BUSY_FETCH & !mcIcacheOk & !clearIn.
  - mcLsbFlag = (BUSY_LOAD & !mcLsbOk & !clearIn) | (BUSY_STORE & !mcLsbOk).
  - Addr/op/data outputs come from latched registers and stay stable through BUSY.
- Completion (readyIn=1, ok=1 in matching BUSY):
  - Next cycle: Done=1 for exactly one cycle; rdData<=mcData for fetch/load.
  - State -> IDLE.
  - Requester deasserts req the cycle it sees Done; the arbiter does not re-grant in the Done cycle, so min spacing is 1 idle cycle.
- clearIn=1 with readyIn=1:
  - BUSY_FETCH/BUSY_LOAD -> IDLE; no Done; rdData unchanged.
  - BUSY_STORE unaffected.
  - A pending Done pulse for fetch/load in that cycle is suppressed; storeDone is not.
- Simultaneous clear and ok on a load: clear wins, no loadDone.
- Requests that drop before grant are harmless. Req changes during BUSY are ignored until IDLE.
- Latency: grant 1 cycle after req seen in IDLE; Done 1 cycle after ok.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds outputs perfFetchGnt, perfLoadGnt, perfStoreGnt, perfStarveForce (32-bit each, wrapping).
  - Each grant increments the matching counter.
  - perfStarveForce counts fetch grants won through the STARVE_LIMIT rule.
  - All counters reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: state encodings; op bit meanings (bit2 store, size codes 00/01/11); STARVE counter width constant (4 bits).
- One sub-module: mem_arb_pick. Combinational priority select plus registered saturating starve counter; outputs grant one-hot.

Test Plan:
- Reset, then fetchReq, fetchAddr=0x100, mcIcacheOk after 4 cycles with mcData=0xDEADBEEF -> mcIcacheFlag high 4 cycles; fetchDone one cycle later; rdData=0xDEADBEEF.
- storeReq and loadReq and fetchReq together (STARVE_LIMIT=4) -> grant order store, load, then fetch; starveCnt reaches 2 then clears.
- Loads/stores back-to-back, fetchReq held -> after exactly 4 data grants the next grant is fetch even with storeReq=1.
- Load in flight, clearIn pulse -> mcLsbFlag drops same cycle, no loadDone, state IDLE; store in flight with clearIn -> storeDone still pulses.
- mcLsbOk=1 while readyIn=0 for 3 cycles -> no state change; completes on first readyIn=1 cycle.
- Reset asserted (resetIn=0) mid-BUSY_STORE -> all flags/Done 0 next cycle; rdData=0.
